// File: rtl/membus_avl_master_pkg.sv
// Shared types, widths and address-field helpers for the Avalon-to-membus master.
// Bit [35] of every data word is PDP bit 0; membus_ma[14] is PDP address bit 21.
package membus_avl_master_pkg;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned DATA_W  = 36;
    localparam int unsigned MA_W    = 15;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned SEL_LSB = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDW,
        ST_WDAT,
        ST_WRS,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // sel and ma overlap on PDP address bit 21 (s_address[14])
    function automatic logic [SEL_W-1:0] addr_sel(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:SEL_LSB];
    endfunction

    function automatic logic [MA_W-1:0] addr_ma(input logic [ADDR_W-1:0] a);
        return a[MA_W-1:0];
    endfunction

endpackage

// File: rtl/membus_avl_master_tmo.sv
// Loadable down-counter; expired_c is high once the loaded count has run out.
module membus_avl_master_tmo #(
    parameter int unsigned LOAD_VAL = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LOAD_VAL + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/membus_avl_master.sv
// Avalon-MM 36-bit slave that runs complete PDP-6 membus cycles on one core port.
// Define MEMBUS_TIMEOUT_EN to bound the addr_ack/rd_rs waits and report s_nxm.
module membus_avl_master
    import membus_avl_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_waitrequest,
    output logic              s_nxm,
    output logic              membus_rq_cyc,
    output logic              membus_rd_rq,
    output logic              membus_wr_rq,
    output logic              membus_wr_rs,
    output logic [MA_W-1:0]   membus_ma,
    output logic [SEL_W-1:0]  membus_sel,
    output logic              membus_fmc_select,
    output logic [DATA_W-1:0] membus_mb_out,
    input  logic              membus_addr_ack,
    input  logic              membus_rd_rs,
    input  logic [DATA_W-1:0] membus_mb_in
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              nxm_q, nxm_d;
    logic              waitreq_q, waitreq_d;
    logic              rq_cyc_q, rq_cyc_d;
    logic              rd_rq_q, rd_rq_d;
    logic              wr_rq_q, wr_rq_d;
    logic              wr_rs_q, wr_rs_d;
    logic [MA_W-1:0]   ma_q, ma_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] mb_out_q, mb_out_d;
    logic              tmo_expired;

`ifdef MEMBUS_TIMEOUT_EN
    logic tmo_load;

    // Restart the wait budget on every entry into a waiting state
    assign tmo_load = (state_d != state_q) && ((state_d == ST_REQ) || (state_d == ST_RDW));

    membus_avl_master_tmo #(
        .LOAD_VAL (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .load      (tmo_load),
        .expired_c (tmo_expired)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign tmo_expired    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        acc_d      = acc_q;
        readdata_d = readdata_q;
        nxm_d      = nxm_q;

        case (state_q)
            ST_IDLE: begin
                if (s_write || s_read) begin
                    cmd_d.is_wr = s_write;
                    cmd_d.addr  = s_address;
                    cmd_d.data  = s_writedata;
                    acc_d       = '0;
                    nxm_d       = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (membus_addr_ack) begin
                    state_d = cmd_q.is_wr ? ST_WDAT : ST_RDW;
                end else if (tmo_expired) begin
                    readdata_d = '0;
                    nxm_d      = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_RDW: begin
                // Data arrives as ORed pulses, possibly spread over several cycles
                acc_d = acc_q | membus_mb_in;
                if (membus_rd_rs) begin
                    readdata_d = acc_q | membus_mb_in;
                    state_d    = ST_DONE;
                end else if (tmo_expired) begin
                    readdata_d = '0;
                    nxm_d      = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_WDAT: state_d = ST_WRS;
            ST_WRS:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered decodes of the state being entered
        rq_cyc_d  = (state_d == ST_REQ);
        rd_rq_d   = (state_d == ST_REQ) && !cmd_d.is_wr;
        wr_rq_d   = (state_d == ST_REQ) && cmd_d.is_wr;
        ma_d      = (state_d == ST_REQ) ? addr_ma(cmd_d.addr) : '0;
        sel_d     = (state_d == ST_REQ) ? addr_sel(cmd_d.addr) : '0;
        mb_out_d  = ((state_d == ST_WDAT) || (state_d == ST_WRS)) ? cmd_d.data : '0;
        wr_rs_d   = (state_d == ST_WRS);
        waitreq_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            acc_q      <= '0;
            readdata_q <= '0;
            nxm_q      <= 1'b0;
            waitreq_q  <= 1'b1;
            rq_cyc_q   <= 1'b0;
            rd_rq_q    <= 1'b0;
            wr_rq_q    <= 1'b0;
            wr_rs_q    <= 1'b0;
            ma_q       <= '0;
            sel_q      <= '0;
            mb_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            acc_q      <= acc_d;
            readdata_q <= readdata_d;
            nxm_q      <= nxm_d;
            waitreq_q  <= waitreq_d;
            rq_cyc_q   <= rq_cyc_d;
            rd_rq_q    <= rd_rq_d;
            wr_rq_q    <= wr_rq_d;
            wr_rs_q    <= wr_rs_d;
            ma_q       <= ma_d;
            sel_q      <= sel_d;
            mb_out_q   <= mb_out_d;
        end
    end

    assign s_readdata        = readdata_q;
    assign s_waitrequest     = waitreq_q;
    assign s_nxm             = nxm_q;
    assign membus_rq_cyc     = rq_cyc_q;
    assign membus_rd_rq      = rd_rq_q;
    assign membus_wr_rq      = wr_rq_q;
    assign membus_wr_rs      = wr_rs_q;
    assign membus_ma         = ma_q;
    assign membus_sel        = sel_q;
    assign membus_fmc_select = 1'b0;
    assign membus_mb_out     = mb_out_q;

endmodule

// File: tb/tb_membus_avl_master.sv
// Bench: host command driver, a behavioural 32K core on port p0 (memsel 0), and a word-level reference memory.
module tb_membus_avl_master;

    logic        clk;
    logic        reset;
    logic [17:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [35:0] s_writedata;
    logic [35:0] s_readdata;
    logic        s_waitrequest;
    logic        s_nxm;
    logic        membus_rq_cyc;
    logic        membus_rd_rq;
    logic        membus_wr_rq;
    logic        membus_wr_rs;
    logic [14:0] membus_ma;
    logic [3:0]  membus_sel;
    logic        membus_fmc_select;
    logic [35:0] membus_mb_out;
    logic        membus_addr_ack;
    logic        membus_rd_rs;
    logic [35:0] membus_mb_in;

    int n_asserts = 0;
    int n_fail    = 0;
    int rd_delay  = 0;
    int wr_rs_cnt = 0;
    int rd_rq_cnt = 0;

    bit [35:0] core_mem [bit [14:0]];
    bit [35:0] exp_mem  [bit [14:0]];

    membus_avl_master #(
        .TIMEOUT (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_address         (s_address),
        .s_read            (s_read),
        .s_write           (s_write),
        .s_writedata       (s_writedata),
        .s_readdata        (s_readdata),
        .s_waitrequest     (s_waitrequest),
        .s_nxm             (s_nxm),
        .membus_rq_cyc     (membus_rq_cyc),
        .membus_rd_rq      (membus_rd_rq),
        .membus_wr_rq      (membus_wr_rq),
        .membus_wr_rs      (membus_wr_rs),
        .membus_ma         (membus_ma),
        .membus_sel        (membus_sel),
        .membus_fmc_select (membus_fmc_select),
        .membus_mb_out     (membus_mb_out),
        .membus_addr_ack   (membus_addr_ack),
        .membus_rd_rs      (membus_rd_rs),
        .membus_mb_in      (membus_mb_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (membus_wr_rs) wr_rs_cnt++;
        if (membus_rd_rq) rd_rq_cnt++;
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    function automatic bit [35:0] exp_read(input bit [14:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 36'd0;
    endfunction

    // Behavioural core: answers cycles whose select matches memsel 0 (sel[18:20] == 0)
    initial begin : core_model
        bit [14:0] a;
        bit        is_rd;
        bit [35:0] word;
        bit [35:0] part;
        int        k;
        membus_addr_ack = 1'b0;
        membus_rd_rs    = 1'b0;
        membus_mb_in    = '0;
        forever begin
            @(negedge clk);
            if (!reset && membus_rq_cyc && (membus_sel[3:1] == 3'b000)) begin
                a     = membus_ma;
                is_rd = membus_rd_rq;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                membus_addr_ack = 1'b1;
                @(negedge clk);
                membus_addr_ack = 1'b0;
                if (!reset) begin
                    check("rq_drop_after_ack",
                          {15'd0, membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_ma, membus_sel}, 36'd0);
                end
                if (is_rd) begin
                    word = core_mem.exists(a) ? core_mem[a] : 36'd0;
                    part = word & {4'($urandom), 32'($urandom)};
                    repeat (rd_delay + $urandom_range(0, 2)) @(negedge clk);
                    membus_mb_in = part;
                    @(negedge clk);
                    membus_mb_in = word ^ part;
                    membus_rd_rs = 1'b1;
                    @(negedge clk);
                    membus_rd_rs = 1'b0;
                    membus_mb_in = '0;
                end else begin
                    k = 0;
                    while (!membus_wr_rs && k < 10) begin
                        @(negedge clk);
                        k++;
                    end
                    check("core_saw_wr_rs", 36'(membus_wr_rs), 36'd1);
                    core_mem[a] = membus_mb_out;
                end
            end
        end
    end

    task automatic host_cmd(input logic wr, input logic rd, input logic [17:0] addr,
                            input logic [35:0] data, output logic [35:0] rdata, output logic nxm);
        int   n;
        logic done;
        @(negedge clk);
        s_write     = wr;
        s_read      = rd;
        s_address   = addr;
        s_writedata = data;
        n     = 0;
        done  = 1'b0;
        rdata = '0;
        nxm   = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (!s_waitrequest) begin
                done  = 1'b1;
                rdata = s_readdata;
                nxm   = s_nxm;
            end
        end
        s_write = 1'b0;
        s_read  = 1'b0;
        check("cmd_completes", 36'(done), 36'd1);
        @(negedge clk);
        check("waitrequest_one_cycle", 36'(s_waitrequest), 36'd1);
    endtask

    initial begin : stimulus
        logic [35:0] rdata;
        logic        nxm;
        int          wr0;
        int          rd0;
        int          k;
        int          n;
        bit [14:0]   a;
        bit [35:0]   d;

        reset       = 1'b1;
        s_address   = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_waitrequest", 36'(s_waitrequest), 36'd1);
        check("reset_readdata", s_readdata, 36'd0);
        check("reset_nxm", 36'(s_nxm), 36'd0);
        check("reset_bus_lines", {22'd0, membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
                                  membus_fmc_select, membus_sel, membus_ma[8:0]}, 36'd0);
        check("reset_ma_mb", {6'd0, membus_ma, 15'd0} | membus_mb_out, 36'd0);
        reset = 1'b0;

        // 1: single write
        wr0 = wr_rs_cnt;
        host_cmd(1'b1, 1'b0, 18'o000100, 36'o123456701234, rdata, nxm);
        exp_mem[15'o00100] = 36'o123456701234;
        check("t1_wr_rs_pulses", 36'(wr_rs_cnt - wr0), 36'd1);
        check("t1_core_word", core_mem[15'o00100], exp_read(15'o00100));

        // 2: read it back
        host_cmd(1'b0, 1'b1, 18'o000100, 36'd0, rdata, nxm);
        check("t2_readdata", rdata, exp_read(15'o00100));

        // 3: read and write together -> write wins
        rd0 = rd_rq_cnt;
        wr0 = wr_rs_cnt;
        host_cmd(1'b1, 1'b1, 18'o000005, 36'o7, rdata, nxm);
        exp_mem[15'o00005] = 36'o7;
        check("t3_no_rd_rq", 36'(rd_rq_cnt - rd0), 36'd0);
        check("t3_wr_rs_pulses", 36'(wr_rs_cnt - wr0), 36'd1);
        check("t3_core_word", core_mem[15'o00005], exp_read(15'o00005));

`ifdef MEMBUS_TIMEOUT_EN
        // 4: unselected memory times out after TIMEOUT+1 cycles in REQ
        @(negedge clk);
        s_read    = 1'b1;
        s_address = 18'o100123;
        k = 0;
        while (!membus_rq_cyc && k < 20) begin
            @(negedge clk);
            k++;
        end
        n = 0;
        while (s_waitrequest && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_done_latency", 36'(n), 36'd17);
        check("t4_readdata_zero", s_readdata, 36'd0);
        check("t4_nxm_set", 36'(s_nxm), 36'd1);
        s_read = 1'b0;
        @(negedge clk);
        check("t4_bus_idle", {32'd0, membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs}, 36'd0);
        host_cmd(1'b0, 1'b1, 18'o000005, 36'd0, rdata, nxm);
        check("t4_nxm_cleared", 36'(nxm), 36'd0);
        check("t4_good_read", rdata, exp_read(15'o00005));
`endif

        // 5: reset while waiting for rd_rs
        rd_delay = 8;
        @(negedge clk);
        s_read    = 1'b1;
        s_address = 18'o000100;
        k = 0;
        while (!membus_rq_cyc && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_rq_seen", 36'(membus_rq_cyc), 36'd1);
        k = 0;
        while (membus_rq_cyc && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_async_bus_zero", {21'd0, membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
                                    membus_sel, membus_ma[7:0]}, 36'd0);
        check("t5_async_data_zero", membus_mb_out | s_readdata | {6'd0, membus_ma, 14'd0, s_nxm}, 36'd0);
        check("t5_async_waitreq", 36'(s_waitrequest), 36'd1);
        s_read = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        rd_delay = 0;
        repeat (15) @(negedge clk);
        host_cmd(1'b0, 1'b1, 18'o000100, 36'd0, rdata, nxm);
        check("t5_read_after_reset", rdata, exp_read(15'o00100));

        // 6: back-to-back write then read at the top of the bank
        host_cmd(1'b1, 1'b0, 18'o077777, 36'o765432107654, rdata, nxm);
        exp_mem[15'o77777] = 36'o765432107654;
        host_cmd(1'b0, 1'b1, 18'o077777, 36'd0, rdata, nxm);
        check("t6_readback", rdata, exp_read(15'o77777));

        // Random mix over a small address window so reads hit earlier writes
        for (int i = 0; i < 24; i++) begin
            a = 15'(16'h0200 + 16'($urandom_range(0, 7)));
            d = {4'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                host_cmd(1'b1, 1'b0, {3'b000, a}, d, rdata, nxm);
                exp_mem[a] = d;
            end else begin
                host_cmd(1'b0, 1'b1, {3'b000, a}, 36'd0, rdata, nxm);
                check("rand_read", rdata, exp_read(a));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
